// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the register file / scoreboard slice.
//   REG_ADDR_W : width of an architectural register index
//   NUM_REGS   : number of architectural registers (x0..x31)
//   XLEN       : default datapath width
//   reg_idx_t  : register index type
package rv32i_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned XLEN       = 32;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/pend_counter.sv
// Saturating pending-write counter for one architectural register.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   inc        : one write issued to this register (0/1)
//   dec        : writes retired or killed this cycle (0..2)
//   count      : current number of in-flight writes
//   err        : combinational pulse, this cycle's update under- or overflows
module pend_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  // Two extra bits: one for the +1 carry, one for the sign of an underflow.
  localparam int unsigned SumW = CNT_W + 2;
  localparam logic signed [SumW-1:0] MaxVal = $signed({2'b00, {CNT_W{1'b1}}});

  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       count_d;
  logic signed [SumW-1:0] sum;

  always_comb begin
    sum = $signed({2'b00, count_q})
        + $signed({{(SumW-1){1'b0}}, inc})
        - $signed({{(SumW-2){1'b0}}, dec});
    count_d = count_q;
    err     = 1'b0;
    if (sum[SumW-1]) begin
      // More retirements than outstanding writes: clamp and flag.
      count_d = '0;
      err     = 1'b1;
    end else if (sum > MaxVal) begin
      count_d = {CNT_W{1'b1}};
      err     = 1'b1;
    end else begin
      count_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rf_scoreboard.sv
// RV32I register file with per-register pending-write scoreboard.
// Sits between ID and WB: serves the two ID read ports (with write-first bypass
// of the WB result), takes the single WB write port, and tracks in-flight
// writers so that ID stalls on a source whose writer has not yet written back.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   rs1_addr_id, rs2_addr_id          : ID source indices
//   rs1_data_id, rs2_data_id          : ID source values (bypassed)
//   issue_valid_id, reg_write_id      : ID issue request, issuing instr writes rd
//   rd_addr_id                        : issuing instruction's destination
//   stall_id                          : ID must hold, issue not accepted
//   reg_write_wb, rd_addr_wb, result_wb : WB write port
//   kill_valid, kill_rd               : squash of a previously issued writer
//   err_o                             : sticky counter under/overflow flag
module rf_scoreboard #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  rv32i_pkg::reg_idx_t rs1_addr_id,
  input  rv32i_pkg::reg_idx_t rs2_addr_id,
  output logic [XLEN-1:0]     rs1_data_id,
  output logic [XLEN-1:0]     rs2_data_id,
  input  logic                issue_valid_id,
  input  logic                reg_write_id,
  input  rv32i_pkg::reg_idx_t rd_addr_id,
  output logic                stall_id,
  input  logic                reg_write_wb,
  input  rv32i_pkg::reg_idx_t rd_addr_wb,
  input  logic [XLEN-1:0]     result_wb,
  input  logic                kill_valid,
  input  rv32i_pkg::reg_idx_t kill_rd,
  output logic                err_o
);

  import rv32i_pkg::*;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  // Entry 0 exists only to keep indexing uniform; it is held at zero.
  logic [XLEN-1:0]  regs_q [NUM_REGS];
  logic [CNT_W-1:0] cnt    [NUM_REGS];
  logic [NUM_REGS-1:0] cnt_err;
  logic             err_q;

  logic wb_en;
  logic wb_hit_rs1;
  logic wb_hit_rs2;
  logic rs1_busy;
  logic rs2_busy;
  logic rd_full;
  logic inc_en;

  assign wb_en = reg_write_wb && (rd_addr_wb != '0);

  // ---------------------------------------------------------------------------
  // Register file: one write port, x0 never written
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en) begin
      regs_q[rd_addr_wb] <= result_wb;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports with write-first bypass
  // ---------------------------------------------------------------------------
  assign wb_hit_rs1 = wb_en && (rd_addr_wb == rs1_addr_id);
  assign wb_hit_rs2 = wb_en && (rd_addr_wb == rs2_addr_id);

  always_comb begin
    rs1_data_id = '0;
    if (rs1_addr_id != '0) begin
      rs1_data_id = wb_hit_rs1 ? result_wb : regs_q[rs1_addr_id];
    end
  end

  always_comb begin
    rs2_data_id = '0;
    if (rs2_addr_id != '0) begin
      rs2_data_id = wb_hit_rs2 ? result_wb : regs_q[rs2_addr_id];
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  // A source is busy when writers remain after discounting the one retiring
  // this cycle: cnt - hit > 0  <=>  cnt > hit.
  assign rs1_busy = (rs1_addr_id != '0) &&
                    (cnt[rs1_addr_id] > {{(CNT_W-1){1'b0}}, wb_hit_rs1});
  assign rs2_busy = (rs2_addr_id != '0) &&
                    (cnt[rs2_addr_id] > {{(CNT_W-1){1'b0}}, wb_hit_rs2});

  // Uses the registered count on purpose: a same-cycle retirement does not
  // open a slot until the next cycle.
  assign rd_full  = reg_write_id && (rd_addr_id != '0) && (cnt[rd_addr_id] == CntMax);

  assign stall_id = issue_valid_id && (rs1_busy || rs2_busy || rd_full);
  assign inc_en   = issue_valid_id && !stall_id && reg_write_id && (rd_addr_id != '0);

  // ---------------------------------------------------------------------------
  // Pending-write counters, x1..x31
  // ---------------------------------------------------------------------------
  assign cnt[0]     = '0;
  assign cnt_err[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic       inc_r;
    logic [1:0] dec_r;

    assign inc_r = inc_en && (rd_addr_id == reg_idx_t'(r));
    assign dec_r = {1'b0, wb_en && (rd_addr_wb == reg_idx_t'(r))}
                 + {1'b0, kill_valid && (kill_rd == reg_idx_t'(r))};

    pend_counter #(
      .CNT_W (CNT_W)
    ) u_pend_counter (
      .clk   (clk),
      .reset (reset),
      .inc   (inc_r),
      .dec   (dec_r),
      .count (cnt[r]),
      .err   (cnt_err[r])
    );
  end

  // ---------------------------------------------------------------------------
  // Sticky error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (|cnt_err) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: each step drives ID/WB/kill inputs,
// queues the expected outputs, and compares them on the falling edge.
module tb_rf_scoreboard;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1_addr_id;
  logic [4:0]  rs2_addr_id;
  logic [31:0] rs1_data_id;
  logic [31:0] rs2_data_id;
  logic        issue_valid_id;
  logic        reg_write_id;
  logic [4:0]  rd_addr_id;
  logic        stall_id;
  logic        reg_write_wb;
  logic [4:0]  rd_addr_wb;
  logic [31:0] result_wb;
  logic        kill_valid;
  logic [4:0]  kill_rd;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        stall;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  rf_scoreboard #(
    .XLEN  (32),
    .CNT_W (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rs1_addr_id    (rs1_addr_id),
    .rs2_addr_id    (rs2_addr_id),
    .rs1_data_id    (rs1_data_id),
    .rs2_data_id    (rs2_data_id),
    .issue_valid_id (issue_valid_id),
    .reg_write_id   (reg_write_id),
    .rd_addr_id     (rd_addr_id),
    .stall_id       (stall_id),
    .reg_write_wb   (reg_write_wb),
    .rd_addr_wb     (rd_addr_wb),
    .result_wb      (result_wb),
    .kill_valid     (kill_valid),
    .kill_rd        (kill_rd),
    .err_o          (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic set_idle();
    rs1_addr_id    = '0;
    rs2_addr_id    = '0;
    issue_valid_id = 1'b0;
    reg_write_id   = 1'b0;
    rd_addr_id     = '0;
    reg_write_wb   = 1'b0;
    rd_addr_wb     = '0;
    result_wb      = '0;
    kill_valid     = 1'b0;
    kill_rd        = '0;
  endtask

  // One cycle: drive, queue expectations, compare at negedge, advance past posedge.
  task automatic step(input string tag,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic iv, input logic rw, input logic [4:0] rd,
                      input logic wbe, input logic [4:0] wrd, input logic [31:0] wdat,
                      input logic kv, input logic [4:0] krd,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input logic es, input logic ee);
    exp_t e;
    rs1_addr_id    = r1;
    rs2_addr_id    = r2;
    issue_valid_id = iv;
    reg_write_id   = rw;
    rd_addr_id     = rd;
    reg_write_wb   = wbe;
    rd_addr_wb     = wrd;
    result_wb      = wdat;
    kill_valid     = kv;
    kill_rd        = krd;
    exp_q.push_back('{tag, e1, e2, es, ee});
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_val({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val({e.tag, ".rs1"},   rs1_data_id,        e.rs1);
      check_val({e.tag, ".rs2"},   rs2_data_id,        e.rs2);
      check_val({e.tag, ".stall"}, {31'd0, stall_id},  {31'd0, e.stall});
      check_val({e.tag, ".err"},   {31'd0, err_o},     {31'd0, e.err});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // All registers read zero, no stall even with issue requested.
    for (int r = 0; r < 32; r++) begin
      step("rst_rd", 5'(r), 5'(31 - r), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // Write-first bypass and x0 behaviour.
    step("iss5",  0, 0, 1, 1, 5, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0);
    step("byp5",  5, 5, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    step("reg5",  5, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'hDEADBEEF, 0, 0, 0);
    step("wx0",   0, 5, 0, 0, 0, 1, 0, 32'h1234,     0, 0, 0, 32'hDEADBEEF, 0, 0);
    step("rx0",   0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0);

    // RAW on x7: stall until WB retires it, then bypassed value.
    step("iss7",  0, 0, 1, 1, 7, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0);
    step("stl7a", 7, 0, 1, 0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 1, 0);
    step("stl7b", 0, 7, 1, 0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 1, 0);
    step("stl7c", 7, 0, 1, 0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 1, 0);
    step("wb7",   7, 0, 1, 0, 0, 1, 7, 32'h55, 0, 0, 32'h55, 0, 0, 0);

    // Counter full on x3: fourth writer stalls until a retirement lands.
    step("iss3a",   0, 0, 1, 1, 3, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0);
    step("iss3b",   0, 0, 1, 1, 3, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0);
    step("iss3c",   0, 0, 1, 1, 3, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0);
    step("full3a",  0, 0, 1, 1, 3, 0, 0, 32'h0,   0, 0, 0, 0, 1, 0);
    step("full3b",  0, 0, 1, 1, 3, 0, 0, 32'h0,   0, 0, 0, 0, 1, 0);
    step("wbfull3", 0, 0, 1, 1, 3, 1, 3, 32'h300, 0, 0, 0, 0, 1, 0);
    step("acc3",    0, 0, 1, 1, 3, 0, 0, 32'h0,   0, 0, 0, 0, 0, 0);
    step("busy3",   3, 0, 1, 0, 0, 0, 0, 32'h0,   0, 0, 32'h300, 0, 1, 0);
    step("dr3a",    3, 0, 0, 0, 0, 1, 3, 32'h301, 0, 0, 32'h301, 0, 0, 0);
    step("dr3b",    3, 0, 0, 0, 0, 1, 3, 32'h302, 0, 0, 32'h302, 0, 0, 0);
    step("dr3c",    3, 0, 1, 0, 0, 1, 3, 32'h303, 0, 0, 32'h303, 0, 0, 0);
    step("free3",   3, 0, 1, 0, 0, 0, 0, 32'h0,   0, 0, 32'h303, 0, 0, 0);

    // Kill releases x9; a second kill underflows and sets sticky err.
    step("iss9",   0, 0, 1, 1, 9, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    step("kill9",  9, 0, 0, 0, 0, 0, 0, 32'h0, 1, 9, 0, 0, 0, 0);
    step("rd9",    9, 0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    step("kill9b", 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 9, 0, 0, 0, 0);
    step("err1",   0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1);
    step("err2",   9, 0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1);

    // Same-cycle inc and dec on x4 cancel; reader still stalls.
    step("iss4",   0, 0, 1, 1, 4, 0, 0, 32'h0,  0, 0, 0, 0, 0, 1);
    step("iss4wb", 0, 0, 1, 1, 4, 1, 4, 32'h44, 0, 0, 0, 0, 0, 1);
    step("stl4",   4, 0, 1, 0, 0, 0, 0, 32'h0,  0, 0, 32'h44, 0, 1, 1);

    // Reset mid-operation overrides a concurrent write, issue and kill.
    rs1_addr_id    = 5'd4;
    issue_valid_id = 1'b1;
    reg_write_id   = 1'b1;
    rd_addr_id     = 5'd4;
    reg_write_wb   = 1'b1;
    rd_addr_wb     = 5'd4;
    result_wb      = 32'h99;
    kill_valid     = 1'b1;
    kill_rd        = 5'd9;
    reset          = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_idle();
    step("post_rst4", 4, 9, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    step("post_rst5", 5, 3, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
